wb_stage: RTL and testbench

MEM/WB pipeline register and writeback formatter that sits directly upstream of the register file and drives its write port (c_wr, addr_w, data_i).
- Captures MEM-stage results each cycle.
- Formats load data (sign/zero extension, byte-lane select).
- Suppresses writes for bubbles, $0 targets and misaligned loads.
- Counts retired instructions.
The register file forwards data_i combinationally, so these outputs also act as the WB→ID bypass source.

---
 rtl/wb_stage.sv | 117 +++++++++++
 tb/tb_wb_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback formatter driving the register-file write port.
// Define WB_SUBWORD_LOAD_EN to enable byte/halfword load formatting; otherwise every load is a word load.
module wb_stage #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall_i,
   input  logic          flush_i,
   input  logic          m_valid,
   input  logic          m_wr,
   input  logic [AW-1:0] m_waddr,
   input  logic          m_memtoreg,
   input  logic [2:0]    m_ld_type,
   input  logic [DW-1:0] m_alu_res,
   input  logic [DW-1:0] m_rdata,
   output logic          c_wr,
   output logic [AW-1:0] addr_w,
   output logic [DW-1:0] data_i,
   output logic          wb_misalign,
   output logic [31:0]   instret
);

   logic          valid;
   logic          wr;
   logic          memtoreg;
   logic          misalign;
   logic [AW-1:0] waddr;
   logic [DW-1:0] alu_res;
   logic [DW-1:0] rdata;
   logic [DW-1:0] load_data;
   logic          addr_misalign;
   logic          m_misalign;

`ifdef WB_SUBWORD_LOAD_EN
   logic [2:0]  ld_type;
   logic [1:0]  off;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Byte loads are always aligned; halfword loads only care about bit 0.
   always_comb begin
      case (m_ld_type)
         3'b001, 3'b010: addr_misalign = 1'b0;
         3'b011, 3'b100: addr_misalign = m_alu_res[0];
         default:        addr_misalign = |m_alu_res[1:0];
      endcase
   end

   assign off      = alu_res[1:0];
   assign byte_sel = rdata[{off, 3'b000} +: 8];
   assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      case (ld_type)
         3'b001:  load_data = {{(DW-8){byte_sel[7]}}, byte_sel};
         3'b010:  load_data = {{(DW-8){1'b0}}, byte_sel};
         3'b011:  load_data = {{(DW-16){half_sel[15]}}, half_sel};
         3'b100:  load_data = {{(DW-16){1'b0}}, half_sel};
         default: load_data = rdata;
      endcase
   end
`else
   logic ld_type_unused;

   assign ld_type_unused = ^m_ld_type;
   assign addr_misalign  = |m_alu_res[1:0];
   assign load_data      = rdata;
`endif

   assign m_misalign = m_valid & m_memtoreg & addr_misalign;

   // Flush only kills valid; the remaining fields are don't-care once valid is low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid    <= 1'b0;
         wr       <= 1'b0;
         memtoreg <= 1'b0;
         misalign <= 1'b0;
         waddr    <= '0;
         alu_res  <= '0;
         rdata    <= '0;
`ifdef WB_SUBWORD_LOAD_EN
         ld_type  <= 3'b000;
`endif
      end else if (flush_i) begin
         valid <= 1'b0;
      end else if (!stall_i) begin
         valid    <= m_valid;
         wr       <= m_wr;
         memtoreg <= m_memtoreg;
         misalign <= m_misalign;
         waddr    <= m_waddr;
         alu_res  <= m_alu_res;
         rdata    <= m_rdata;
`ifdef WB_SUBWORD_LOAD_EN
         ld_type  <= m_ld_type;
`endif
      end
   end

   // An instruction retires when it leaves WB, which a flush forces even under stall.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instret <= 32'd0;
      end else if (valid && (!stall_i || flush_i)) begin
         instret <= instret + 32'd1;
      end
   end

   assign c_wr        = valid & wr & (waddr != '0) & ~misalign;
   assign addr_w      = waddr;
   assign wb_misalign = valid & misalign;
   assign data_i      = memtoreg ? load_data : alu_res;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: vector table plus hand-written stall/flush/reset sequences,
// with expected writeback results queued at drive time and compared one cycle later.
module tb_wb_stage;

   localparam logic [31:0] RD = 32'h80FF_7F01;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_i;
   logic        flush_i;
   logic        m_valid;
   logic        m_wr;
   logic [4:0]  m_waddr;
   logic        m_memtoreg;
   logic [2:0]  m_ld_type;
   logic [31:0] m_alu_res;
   logic [31:0] m_rdata;
   logic        c_wr;
   logic [4:0]  addr_w;
   logic [31:0] data_i;
   logic        wb_misalign;
   logic [31:0] instret;

   typedef struct {
      string       name;
      logic        valid;
      logic        wr;
      logic [4:0]  waddr;
      logic        memtoreg;
      logic [2:0]  ld_type;
      logic [31:0] alu_res;
      logic [31:0] rdata;
      logic        exp_cwr;
      logic [31:0] exp_data;
      logic        exp_mis;
   } vec_t;

   typedef struct {
      string       name;
      logic        cwr;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        mis;
      logic        chk_data;
      logic [31:0] instret;
   } exp_t;

   vec_t        vecs[$];
   exp_t        sb_q[$];
   exp_t        held;
   logic        model_valid;
   logic [31:0] model_instret;
   int          checks;
   int          failures;

   wb_stage #(.DW(32), .AW(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .stall_i    (stall_i),
      .flush_i    (flush_i),
      .m_valid    (m_valid),
      .m_wr       (m_wr),
      .m_waddr    (m_waddr),
      .m_memtoreg (m_memtoreg),
      .m_ld_type  (m_ld_type),
      .m_alu_res  (m_alu_res),
      .m_rdata    (m_rdata),
      .c_wr       (c_wr),
      .addr_w     (addr_w),
      .data_i     (data_i),
      .wb_misalign(wb_misalign),
      .instret    (instret)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(string n, logic v, logic w, logic [4:0] a, logic m2r,
                               logic [2:0] lt, logic [31:0] alu, logic [31:0] rd,
                               logic cwr, logic [31:0] d, logic mis);
      vec_t r;
      r.name = n; r.valid = v; r.wr = w; r.waddr = a; r.memtoreg = m2r; r.ld_type = lt;
      r.alu_res = alu; r.rdata = rd; r.exp_cwr = cwr; r.exp_data = d; r.exp_mis = mis;
      return r;
   endfunction

   task automatic compare(string what, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", what, act, req);
      end
   endtask

   task automatic resetModel();
      model_valid   = 1'b0;
      model_instret = 32'd0;
      held.name = "idle"; held.cwr = 1'b0; held.addr = 5'd0; held.data = 32'd0;
      held.mis = 1'b0; held.chk_data = 1'b1; held.instret = 32'd0;
   endtask

   task automatic checkOutput();
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $display("[TB] FAIL scoreboard: got empty queue expected an entry");
         return;
      end
      checks--;
      e = sb_q.pop_front();
      compare({e.name, ".c_wr"}, {31'd0, c_wr}, {31'd0, e.cwr});
      compare({e.name, ".wb_misalign"}, {31'd0, wb_misalign}, {31'd0, e.mis});
      compare({e.name, ".instret"}, instret, e.instret);
      if (e.chk_data) begin
         compare({e.name, ".addr_w"}, {27'd0, addr_w}, {27'd0, e.addr});
         compare({e.name, ".data_i"}, data_i, e.data);
      end
   endtask

   // Drives one MEM-stage cycle, advances the reference model and checks after the edge.
   task automatic applyStimulus(vec_t v, logic stall, logic flush);
      @(negedge clk);
      m_valid = v.valid; m_wr = v.wr; m_waddr = v.waddr; m_memtoreg = v.memtoreg;
      m_ld_type = v.ld_type; m_alu_res = v.alu_res; m_rdata = v.rdata;
      stall_i = stall; flush_i = flush;
      if (model_valid && (!stall || flush)) model_instret = model_instret + 32'd1;
      held.name = v.name;
      if (flush) begin
         model_valid = 1'b0;
         held.cwr = 1'b0; held.mis = 1'b0; held.chk_data = 1'b0;
      end else if (!stall) begin
         model_valid = v.valid;
         held.cwr = v.exp_cwr; held.addr = v.waddr; held.data = v.exp_data;
         held.mis = v.exp_mis; held.chk_data = 1'b1;
      end
      held.instret = model_instret;
      sb_q.push_back(held);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      vec_t junk;
      vec_t r9;
      checks = 0; failures = 0;
      resetModel();

      vecs.push_back(mk("alu_r5",     1, 1, 5, 0, 3'b000, 32'h1234_5678, RD, 1, 32'h1234_5678, 0));
      vecs.push_back(mk("zero_dst",   1, 1, 0, 0, 3'b000, 32'hDEAD_BEEF, RD, 0, 32'hDEAD_BEEF, 0));
      vecs.push_back(mk("bubble",     0, 1, 4, 0, 3'b000, 32'hAAAA_5555, RD, 0, 32'hAAAA_5555, 0));
      vecs.push_back(mk("no_wr",      1, 0, 6, 1, 3'b000, 32'h0000_2000, RD, 0, RD, 0));
      vecs.push_back(mk("lw_mis",     1, 1, 7, 1, 3'b000, 32'h0000_1002, RD, 0, RD, 1));
      vecs.push_back(mk("lt7_as_lw",  1, 1, 8, 1, 3'b111, 32'h0000_1000, RD, 1, RD, 0));
      vecs.push_back(mk("bubble_mis", 0, 1, 7, 1, 3'b000, 32'h0000_1001, RD, 0, RD, 0));
`ifdef WB_SUBWORD_LOAD_EN
      vecs.push_back(mk("lb_off2",    1, 1, 3, 1, 3'b001, 32'h0010_0002, RD, 1, 32'hFFFF_FFFF, 0));
      vecs.push_back(mk("lbu_off3",   1, 1, 3, 1, 3'b010, 32'h0000_0103, RD, 1, 32'h0000_0080, 0));
      vecs.push_back(mk("lh_off0",    1, 1, 3, 1, 3'b011, 32'h0000_0100, RD, 1, 32'h0000_7F01, 0));
      vecs.push_back(mk("lhu_off2",   1, 1, 3, 1, 3'b100, 32'h0000_0102, RD, 1, 32'h0000_80FF, 0));
      vecs.push_back(mk("lb_off3",    1, 1, 3, 1, 3'b001, 32'h0000_0103, RD, 1, 32'hFFFF_FF80, 0));
      vecs.push_back(mk("lb_off1",    1, 1, 3, 1, 3'b001, 32'h0000_0101, RD, 1, 32'h0000_007F, 0));
      vecs.push_back(mk("lbu_off0",   1, 1, 3, 1, 3'b010, 32'h0000_0100, RD, 1, 32'h0000_0001, 0));
      vecs.push_back(mk("lbu_off2",   1, 1, 3, 1, 3'b010, 32'h0000_0102, RD, 1, 32'h0000_00FF, 0));
      vecs.push_back(mk("lh_off2",    1, 1, 3, 1, 3'b011, 32'h0000_0102, RD, 1, 32'hFFFF_80FF, 0));
      vecs.push_back(mk("lh_off1",    1, 1, 3, 1, 3'b011, 32'h0000_0101, RD, 0, 32'h0000_7F01, 1));
      vecs.push_back(mk("lhu_off3",   1, 1, 3, 1, 3'b100, 32'h0000_0103, RD, 0, 32'h0000_80FF, 1));
`else
      vecs.push_back(mk("lb_off0",    1, 1, 3, 1, 3'b001, 32'h0000_1000, RD, 1, RD, 0));
      vecs.push_back(mk("lb_off2",    1, 1, 3, 1, 3'b001, 32'h0010_0002, RD, 0, RD, 1));
      vecs.push_back(mk("lbu_off3",   1, 1, 3, 1, 3'b010, 32'h0000_0103, RD, 0, RD, 1));
      vecs.push_back(mk("lh_off0",    1, 1, 3, 1, 3'b011, 32'h0000_0100, RD, 1, RD, 0));
      vecs.push_back(mk("lhu_off2",   1, 1, 3, 1, 3'b100, 32'h0000_0102, RD, 0, RD, 1));
`endif

      // Reset held with live inputs: nothing may be captured.
      reset = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
      m_valid = 1'b1; m_wr = 1'b1; m_waddr = 5'd5; m_memtoreg = 1'b0;
      m_ld_type = 3'b000; m_alu_res = 32'h0000_0055; m_rdata = RD;
      repeat (2) @(posedge clk);
      #1;
      compare("reset.c_wr", {31'd0, c_wr}, 32'd0);
      compare("reset.addr_w", {27'd0, addr_w}, 32'd0);
      compare("reset.data_i", data_i, 32'd0);
      compare("reset.wb_misalign", {31'd0, wb_misalign}, 32'd0);
      compare("reset.instret", instret, 32'd0);
      @(negedge clk);
      m_valid = 1'b0; m_wr = 1'b0;
      reset = 1'b1;

      foreach (vecs[i]) applyStimulus(vecs[i], 1'b0, 1'b0);

      junk = mk("junk", 1, 1, 5'd12, 0, 3'b000, 32'hCAFE_0000, RD, 1, 32'hCAFE_0000, 0);
      r9   = mk("r9",   1, 1, 5'd9,  0, 3'b000, 32'h9999_0009, RD, 1, 32'h9999_0009, 0);

      applyStimulus(r9, 1'b0, 1'b0);
      repeat (3) applyStimulus(junk, 1'b1, 1'b0);
      applyStimulus(junk, 1'b1, 1'b1);
      applyStimulus(r9, 1'b0, 1'b0);
      applyStimulus(junk, 1'b0, 1'b1);
      applyStimulus(junk, 1'b0, 1'b0);
      applyStimulus(junk, 1'b1, 1'b0);

      // Reset dropped between edges must kill the pending write immediately.
      #2;
      reset = 1'b0;
      #1;
      compare("midreset.c_wr", {31'd0, c_wr}, 32'd0);
      compare("midreset.wb_misalign", {31'd0, wb_misalign}, 32'd0);
      compare("midreset.instret", instret, 32'd0);
      compare("midreset.data_i", data_i, 32'd0);
      resetModel();
      @(negedge clk);
      stall_i = 1'b0; flush_i = 1'b0; m_valid = 1'b0;
      reset = 1'b1;
      applyStimulus(r9, 1'b0, 1'b0);
      applyStimulus(junk, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("[TB] FAIL timeout: got no completion expected finish before 50000");
      $fatal(1, "[TB] timeout");
   end

endmodule
